// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the display register block and the binary-to-BCD converter.
// The master drives start/bin. The slave (the converter) drives busy/valid/bcd.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 26,
    parameter int DIGITS = 8
);
    logic                  i_start;
    logic [BIN_W-1:0]      i_bin;
    logic                  o_busy;
    logic                  o_valid;
    logic [4*DIGITS-1:0]   o_bcd;

    modport master (
        output i_start,
        output i_bin,
        input  o_busy,
        input  o_valid,
        input  o_bcd
    );

    modport slave (
        input  i_start,
        input  i_bin,
        output o_busy,
        output o_valid,
        output o_bcd
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock into packed BCD digits.
// Optional leading-zero blanking (digits above the top nonzero digit become 4'hF) under BIN2BCD_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for i_start; o_bcd holds the last result
// SHIFT | add-3 correction then one left shift per cycle, BIN_W cycles
// DONE  | scratch is final; publish to o_bcd and pulse o_valid on leaving
module bin2bcd_seq #(
    parameter int BIN_W  = 26,
    parameter int DIGITS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    bin2bcd_seq_if.slave    bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int TOT_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]  scratch_q, scratch_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              valid_q, valid_d;

    logic [BCD_W-1:0]  adj;
    logic [TOT_W-1:0]  shifted;
    logic [BCD_W-1:0]  bcd_out;

    // Correction is applied to every digit before the shift; the top digit's carry is dropped by the shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, shift_q} << 1;
    end

`ifdef BIN2BCD_BLANK_EN
    always_comb begin
        logic seen_nz;
        seen_nz = 1'b0;
        bcd_out = scratch_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (scratch_q[4*i +: 4] != 4'h0) begin
                seen_nz = 1'b1;
            end
            if (!seen_nz) begin
                bcd_out[4*i +: 4] = 4'hF;
            end
        end
    end
`else
    assign bcd_out = scratch_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d   = S_SHIFT;
                    shift_d   = bus.i_bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                end
            end
            S_SHIFT: begin
                scratch_d = shifted[TOT_W-1:BIN_W];
                shift_d   = shifted[BIN_W-1:0];
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d   = bcd_out;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
        end
    end

    // Busy covers DONE as well, so it falls on the same edge that raises o_valid.
    assign bus.o_busy  = (state_q != S_IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_bcd   = bcd_q;

endmodule
